// File: rtl/stopwatch_lap.sv
// ============================================================================
// Module   : stopwatch_lap
// Purpose  : Millisecond stopwatch with up/down counting, preset load,
//            countdown completion and a FIFO lap-capture buffer.
//            All state advances on the falling edge of the 1 kHz clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_lap #(
  parameter int HOUR_WRAP = 12,
  parameter int HOUR_W    = 4,
  parameter int LAP_DEPTH = 8
) (
  input  logic                         Clock_1MSec,
  input  logic                         Reset,
  input  logic                         Control,
  input  logic                         Start_S,
  input  logic                         Stop_S,
  input  logic                         Reset_S,
  input  logic                         Lap_S,
  input  logic                         Lap_Rd,
  input  logic                         Mode_S,
  input  logic                         Load_S,
  input  logic [HOUR_W-1:0]            Hours_L,
  input  logic [5:0]                   Mins_L,
  input  logic [5:0]                   Secs_L,
  output logic [HOUR_W-1:0]            Hours_S,
  output logic [5:0]                   Mins_S,
  output logic [5:0]                   Secs_S,
  output logic [9:0]                   MSecs_S,
  output logic [HOUR_W-1:0]            Lap_Hours,
  output logic [5:0]                   Lap_Mins,
  output logic [5:0]                   Lap_Secs,
  output logic [9:0]                   Lap_MSecs,
  output logic [$clog2(LAP_DEPTH):0]   Lap_Count,
  output logic                         Lap_Ovf,
  output logic                         Running,
  output logic                         Done
);

  localparam int PTR_W  = $clog2(LAP_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TIME_W = HOUR_W + 22;
  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(HOUR_WRAP - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(LAP_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [HOUR_W-1:0] hours;
  logic [5:0]        mins;
  logic [5:0]        secs;
  logic [9:0]        msecs;
  logic              count_down;

  logic do_clear, do_load, do_tick, latch_dir;
  logic time_zero, down_hits_zero;

  // time field helpers
  logic ms_top, s_top, m_top, h_top;
  logic ms_bot, s_bot, m_bot, h_bot;
  logic [HOUR_W-1:0] up_h, dn_h, sat_h;
  logic [5:0]        up_m, dn_m, sat_m;
  logic [5:0]        up_s, dn_s, sat_s;
  logic [9:0]        up_ms, dn_ms;

  // lap FIFO
  logic [TIME_W-1:0] lap_mem [LAP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  lap_cnt;
  logic              lap_ovf;
  logic              lap_req, pop, push, drop, lap_full, lap_empty;
  logic [TIME_W-1:0] lap_head;

  assign time_zero      = (hours == '0) && (mins == '0) && (secs == '0) && (msecs == '0);
  assign down_hits_zero = (hours == '0) && (mins == '0) && (secs == '0) && (msecs == 10'd1);

  assign ms_top = (msecs == 10'd999);
  assign s_top  = (secs  == 6'd59);
  assign m_top  = (mins  == 6'd59);
  assign h_top  = (hours == HOUR_MAX);
  assign ms_bot = (msecs == '0);
  assign s_bot  = (secs  == '0);
  assign m_bot  = (mins  == '0);
  assign h_bot  = (hours == '0);

  // Count-up successor: every carry ripples within the same edge
  assign up_ms = ms_top ? 10'd0 : msecs + 10'd1;
  assign up_s  = ms_top ? (s_top ? 6'd0 : secs + 6'd1) : secs;
  assign up_m  = (ms_top && s_top) ? (m_top ? 6'd0 : mins + 6'd1) : mins;
  assign up_h  = (ms_top && s_top && m_top) ? (h_top ? '0 : hours + HOUR_W'(1)) : hours;

  // Count-down predecessor: borrows mirror the carries
  assign dn_ms = ms_bot ? 10'd999 : msecs - 10'd1;
  assign dn_s  = ms_bot ? (s_bot ? 6'd59 : secs - 6'd1) : secs;
  assign dn_m  = (ms_bot && s_bot) ? (m_bot ? 6'd59 : mins - 6'd1) : mins;
  assign dn_h  = (ms_bot && s_bot && m_bot) ? (h_bot ? HOUR_MAX : hours - HOUR_W'(1)) : hours;

  // Out-of-range presets clamp to the largest legal field value
  assign sat_h = (Hours_L > HOUR_MAX) ? HOUR_MAX : Hours_L;
  assign sat_m = (Mins_L  > 6'd59)    ? 6'd59    : Mins_L;
  assign sat_s = (Secs_L  > 6'd59)    ? 6'd59    : Secs_L;

  // State register
  always_ff @(negedge Clock_1MSec or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath control; Control freezes everything
  always_comb begin
    state_next = state;
    do_clear   = 1'b0;
    do_load    = 1'b0;
    do_tick    = 1'b0;
    latch_dir  = 1'b0;
    if (!Control) begin
      case (state)
        IDLE: begin
          if (Reset_S) begin
            do_clear = 1'b1;
          end else if (Stop_S) begin
            state_next = IDLE;
          end else if (Start_S) begin
            latch_dir  = 1'b1;
            state_next = (Mode_S && time_zero) ? DONE : RUN;
          end else if (Load_S) begin
            do_load = 1'b1;
          end
        end
        RUN: begin
          if (Stop_S) begin
            state_next = PAUSE;
          end else if (count_down && time_zero) begin
            state_next = DONE;
          end else begin
            do_tick = 1'b1;
            if (count_down && down_hits_zero) state_next = DONE;
          end
        end
        PAUSE: begin
          if (Reset_S) begin
            do_clear   = 1'b1;
            state_next = IDLE;
          end else if (Stop_S) begin
            state_next = PAUSE;
          end else if (Start_S) begin
            state_next = RUN;
          end
        end
        DONE: begin
          if (Reset_S) begin
            do_clear   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Live time counters
  always_ff @(negedge Clock_1MSec or negedge Reset) begin
    if (!Reset) begin
      hours <= '0;
      mins  <= '0;
      secs  <= '0;
      msecs <= '0;
    end else if (do_clear) begin
      hours <= '0;
      mins  <= '0;
      secs  <= '0;
      msecs <= '0;
    end else if (do_load) begin
      hours <= sat_h;
      mins  <= sat_m;
      secs  <= sat_s;
      msecs <= '0;
    end else if (do_tick) begin
      hours <= count_down ? dn_h  : up_h;
      mins  <= count_down ? dn_m  : up_m;
      secs  <= count_down ? dn_s  : up_s;
      msecs <= count_down ? dn_ms : up_ms;
    end
  end

  // Counting direction, captured when a run is started from IDLE
  always_ff @(negedge Clock_1MSec or negedge Reset) begin
    if (!Reset)         count_down <= 1'b0;
    else if (latch_dir) count_down <= Mode_S;
  end

  assign lap_full  = (lap_cnt == CNT_FULL);
  assign lap_empty = (lap_cnt == '0);
  assign lap_req   = !Control && !do_clear && Lap_S && ((state == RUN) || (state == PAUSE));
  assign pop       = !Control && !do_clear && Lap_Rd && !lap_empty;
  assign push      = lap_req && (!lap_full || pop);
  assign drop      = lap_req && lap_full && !pop;

  // Lap storage holds the pre-update time of the capturing edge
  always_ff @(negedge Clock_1MSec) begin
    if (push) lap_mem[wr_ptr] <= {hours, mins, secs, msecs};
  end

  // Lap pointers, occupancy and sticky overflow
  always_ff @(negedge Clock_1MSec or negedge Reset) begin
    if (!Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lap_cnt <= '0;
      lap_ovf <= 1'b0;
    end else if (do_clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lap_cnt <= '0;
      lap_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      lap_cnt <= lap_cnt + CNT_W'(1);
      else if (pop && !push) lap_cnt <= lap_cnt - CNT_W'(1);
      if (drop) lap_ovf <= 1'b1;
    end
  end

  assign lap_head = lap_empty ? '0 : lap_mem[rd_ptr];

  assign {Lap_Hours, Lap_Mins, Lap_Secs, Lap_MSecs} = lap_head;
  assign Hours_S   = hours;
  assign Mins_S    = mins;
  assign Secs_S    = secs;
  assign MSecs_S   = msecs;
  assign Lap_Count = lap_cnt;
  assign Lap_Ovf   = lap_ovf;
  assign Running   = (state == RUN);
  assign Done      = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_lap.sv
// ============================================================================
// Module   : tb_stopwatch_lap
// Purpose  : Self-checking bench for stopwatch_lap; time is modelled as a
//            single millisecond total and the lap buffer as a queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_lap;

  localparam int HOUR_WRAP = 12;
  localparam int HOUR_W    = 4;
  localparam int LAP_DEPTH = 8;
  localparam int MS_H      = 3600000;
  localparam int MS_M      = 60000;
  localparam int MODULUS   = HOUR_WRAP * MS_H;

  logic clk, rst_n, control, start_s, stop_s, reset_s, lap_s, lap_rd, mode_s, load_s;
  logic [HOUR_W-1:0] hours_l;
  logic [5:0] mins_l, secs_l;
  logic [HOUR_W-1:0] hours_o, lap_hours;
  logic [5:0] mins_o, secs_o, lap_mins, lap_secs;
  logic [9:0] msecs_o, lap_msecs;
  logic [3:0] lap_count;
  logic lap_ovf, running, done;

  stopwatch_lap #(.HOUR_WRAP(HOUR_WRAP), .HOUR_W(HOUR_W), .LAP_DEPTH(LAP_DEPTH)) dut (
    .Clock_1MSec(clk), .Reset(rst_n), .Control(control),
    .Start_S(start_s), .Stop_S(stop_s), .Reset_S(reset_s), .Lap_S(lap_s),
    .Lap_Rd(lap_rd), .Mode_S(mode_s), .Load_S(load_s),
    .Hours_L(hours_l), .Mins_L(mins_l), .Secs_L(secs_l),
    .Hours_S(hours_o), .Mins_S(mins_o), .Secs_S(secs_o), .MSecs_S(msecs_o),
    .Lap_Hours(lap_hours), .Lap_Mins(lap_mins), .Lap_Secs(lap_secs), .Lap_MSecs(lap_msecs),
    .Lap_Count(lap_count), .Lap_Ovf(lap_ovf), .Running(running), .Done(done)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // reference model: 0 idle, 1 run, 2 pause, 3 done
  int m_t, m_st;
  bit m_dn, m_ovf;
  int m_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_t(input int t);
    int h, m, s, ms;
    h  = t / MS_H;
    m  = (t / MS_M) % 60;
    s  = (t / 1000) % 60;
    ms = t % 1000;
    return {38'd0, 4'(h), 6'(m), 6'(s), 10'(ms)};
  endfunction

  function automatic int preset_ms();
    int h, m, s;
    h = (int'(hours_l) > HOUR_WRAP - 1) ? HOUR_WRAP - 1 : int'(hours_l);
    m = (int'(mins_l) > 59) ? 59 : int'(mins_l);
    s = (int'(secs_l) > 59) ? 59 : int'(secs_l);
    return h * MS_H + m * MS_M + s * 1000;
  endfunction

  task automatic model_reset();
    m_t = 0; m_st = 0; m_dn = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic model_edge();
    int pre, pst;
    bit clr, do_pop, do_push;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (control) return;
    pre = m_t; pst = m_st; clr = 0;
    case (m_st)
      0: begin
        if (reset_s) begin m_t = 0; clr = 1; end
        else if (stop_s) begin end
        else if (start_s) begin
          m_dn = mode_s;
          m_st = (mode_s && m_t == 0) ? 3 : 1;
        end
        else if (load_s) m_t = preset_ms();
      end
      1: begin
        if (stop_s) m_st = 2;
        else if (m_dn) begin
          m_t = m_t - 1;
          if (m_t == 0) m_st = 3;
        end
        else m_t = (m_t + 1) % MODULUS;
      end
      2: begin
        if (reset_s) begin m_t = 0; clr = 1; m_st = 0; end
        else if (stop_s) begin end
        else if (start_s) m_st = 1;
      end
      default: begin
        if (reset_s) begin m_t = 0; clr = 1; m_st = 0; end
      end
    endcase
    if (clr) begin
      m_q.delete();
      m_ovf = 0;
    end else begin
      do_pop  = lap_rd && (m_q.size() > 0);
      do_push = lap_s && (pst == 1 || pst == 2);
      if (do_push && m_q.size() == LAP_DEPTH && !do_pop) begin
        m_ovf = 1;
        do_push = 0;
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(pre);
    end
  endtask

  task automatic check_all();
    chk("time", 64'({hours_o, mins_o, secs_o, msecs_o}), pack_t(m_t));
    chk("lap_head", 64'({lap_hours, lap_mins, lap_secs, lap_msecs}),
        (m_q.size() > 0) ? pack_t(m_q[0]) : 64'd0);
    chk("lap_count", 64'(lap_count), 64'(m_q.size()));
    chk("lap_ovf", 64'(lap_ovf), 64'(m_ovf));
    chk("running", 64'(running), 64'(m_st == 1));
    chk("done", 64'(done), 64'(m_st == 3));
  endtask

  task automatic quiet();
    control = 0; start_s = 0; stop_s = 0; reset_s = 0; lap_s = 0;
    lap_rd = 0; load_s = 0;
  endtask

  // one falling edge: model updates after it, DUT sampled half a period later
  task automatic step();
    @(negedge clk); #1;
    model_edge();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic pulse_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_preset(input int h, input int m, input int s);
    quiet();
    hours_l = 4'(h); mins_l = 6'(m); secs_l = 6'(s);
    load_s = 1; step(); quiet();
  endtask

  task automatic go(input bit dn);
    quiet(); mode_s = dn; start_s = 1; step(); quiet();
  endtask

  task automatic halt_and_clear();
    quiet(); stop_s = 1; step();
    quiet(); reset_s = 1; step(); quiet();
  endtask

  int t_hold;

  initial begin
    quiet();
    mode_s = 0; hours_l = 0; mins_l = 0; secs_l = 0;
    rst_n = 0;
    model_reset();
    #12;
    chk("rst_time", 64'({hours_o, mins_o, secs_o, msecs_o}), 64'd0);
    chk("rst_count", 64'(lap_count), 64'd0);
    chk("rst_flags", 64'({lap_ovf, running, done}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // an hour boundary from a preset near it
    load_preset(0, 59, 59);
    go(0);
    pulse_steps(1000);
    chk("hour_carry", 64'({hours_o, mins_o, secs_o, msecs_o}), pack_t(MS_H));
    chk("hour_running", 64'(running), 64'd1);
    halt_and_clear();

    // modulus wrap: 11:59:59 + 1 s -> 0:00:00.000, not Done
    load_preset(11, 59, 59);
    go(0);
    pulse_steps(1000);
    chk("wrap_time", 64'({hours_o, mins_o, secs_o, msecs_o}), 64'd0);
    chk("wrap_done", 64'(done), 64'd0);
    halt_and_clear();

    // saturating preset
    load_preset(15, 63, 60);
    chk("sat_load", 64'({hours_o, mins_o, secs_o, msecs_o}), pack_t(11 * MS_H + 59 * MS_M + 59000));
    quiet(); reset_s = 1; step(); quiet();

    // countdown to zero enters DONE and holds
    load_preset(0, 0, 2);
    go(1);
    pulse_steps(2000);
    chk("cd_zero", 64'({hours_o, mins_o, secs_o, msecs_o}), 64'd0);
    chk("cd_flags", 64'({running, done}), 64'b01);
    start_s = 1;
    pulse_steps(5);
    quiet();
    chk("cd_hold", 64'({hours_o, mins_o, secs_o, msecs_o, done}), 64'd1);
    reset_s = 1; step(); quiet();

    // down start from zero goes straight to DONE
    go(1);
    chk("zero_start_done", 64'(done), 64'd1);
    reset_s = 1; step(); quiet();

    // lap overflow, head is first capture, drain
    go(0);
    pulse_steps(5);
    lap_s = 1;
    pulse_steps(9);
    quiet();
    chk("lap_full", 64'({lap_count, lap_ovf}), 64'({4'd8, 1'b1}));
    chk("lap_first", 64'({lap_hours, lap_mins, lap_secs, lap_msecs}), 64'd5);
    lap_rd = 1;
    pulse_steps(8);
    quiet();
    chk("lap_drained", 64'(lap_count), 64'd0);

    // Reset_S ignored in RUN, Control freezes
    reset_s = 1; step(); quiet();
    chk("rs_in_run", 64'(running), 64'd1);
    t_hold = m_t;
    control = 1;
    for (int i = 0; i < 100; i++) begin
      start_s = 1'($urandom); stop_s = 1'($urandom); reset_s = 1'($urandom);
      lap_s = 1'($urandom); lap_rd = 1'($urandom);
      step();
    end
    quiet();
    chk("ctrl_frozen", 64'({hours_o, mins_o, secs_o, msecs_o}), pack_t(t_hold));
    halt_and_clear();
    chk("cleared", 64'({hours_o, mins_o, secs_o, msecs_o, lap_count, running, done}), 64'd0);

    // asynchronous reset between edges
    go(0);
    lap_s = 1;
    pulse_steps(10);
    quiet();
    rst_n = 0;
    #1;
    chk("async_rst", 64'({hours_o, mins_o, secs_o, msecs_o, lap_count, lap_ovf, running, done}), 64'd0);
    model_reset();
    #1;
    rst_n = 1;
    step();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      control = ($urandom_range(0, 99) < 4);
      reset_s = ($urandom_range(0, 99) < 3);
      stop_s  = ($urandom_range(0, 99) < 5);
      start_s = ($urandom_range(0, 99) < 12);
      load_s  = ($urandom_range(0, 99) < 8);
      lap_s   = ($urandom_range(0, 99) < 20);
      lap_rd  = ($urandom_range(0, 99) < 12);
      mode_s  = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        hours_l = 4'($urandom_range(0, 15));
        mins_l  = 6'($urandom_range(0, 63));
        secs_l  = 6'($urandom_range(0, 63));
      end else begin
        hours_l = 0; mins_l = 0;
        secs_l  = 6'($urandom_range(0, 1));
      end
      step();
    end
    quiet();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_lap.md
STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 Parameter HOUR_WRAP, default 12: hours modulus; hours count 0..HOUR_WRAP-1.
REQ-002 Parameter HOUR_W, default 4: hours field width; SHALL satisfy 2^HOUR_W >= HOUR_WRAP.
REQ-003 Parameter LAP_DEPTH, default 8: lap buffer entries; power of two, >= 2.
REQ-004 Clock_1MSec  in  1  1 kHz clock; all state updates on its falling edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 Control  in  1  0 = block active; 1 = all other inputs ignored, state and counters frozen.
REQ-007 Start_S  in  1  level request: start or resume counting.
REQ-008 Stop_S  in  1  level request: pause counting.
REQ-009 Reset_S  in  1  level request: clear time, lap buffer and overflow flag.
REQ-010 Lap_S  in  1  capture current time into the lap buffer.
REQ-011 Lap_Rd  in  1  pop the oldest lap entry.
REQ-012 Mode_S  in  1  0 = count up, 1 = count down; sampled only in IDLE.
REQ-013 Load_S  in  1  load preset time (IDLE only).
REQ-014 Hours_L/Mins_L/Secs_L  in  HOUR_W/6/6  preset value; MSecs loads as 0.
REQ-015 Hours_S/Mins_S/Secs_S/MSecs_S  out  HOUR_W/6/6/10  live time.
REQ-016 Lap_Hours/Lap_Mins/Lap_Secs/Lap_MSecs  out  HOUR_W/6/6/10  oldest lap entry (fall-through); 0 when empty.
REQ-017 Lap_Count  out  clog2(LAP_DEPTH)+1  entries held; Lap_Ovf  out  1  sticky lap-drop flag.
REQ-018 Running  out  1  high in RUN; Done  out  1  high in DONE.

Function
REQ-019 FSM states IDLE, RUN, PAUSE, DONE; all inputs sampled on the falling clock edge; priority Reset_S > Stop_S > Start_S > Load_S.
REQ-020 IDLE: Start_S -> RUN (direction latched from Mode_S); Load_S -> counters take preset; Reset_S -> zero.
REQ-021 RUN: Stop_S -> PAUSE; Reset_S ignored; otherwise advance time 1 ms per edge.
REQ-022 PAUSE: Start_S -> RUN; Reset_S -> IDLE with clear; counters hold.
REQ-023 DONE: counters hold at zero; Reset_S -> IDLE with clear; Start_S ignored.
REQ-024 Count up: MSecs 999->0 carries to Secs; Secs 59->0 to Mins; Mins 59->0 to Hours; Hours HOUR_WRAP-1->0; all carries in the same edge.
REQ-025 Count down: borrows mirror REQ-024; the edge producing 0:00:00.000 SHALL enter DONE the same edge; no underflow.
REQ-026 Start_S in IDLE, down mode, time zero: SHALL go directly to DONE.
REQ-027 Preset Mins_L/Secs_L > 59 or Hours_L >= HOUR_WRAP: load SHALL saturate field to max legal value.
REQ-028 Lap_S in RUN or PAUSE pushes the pre-update time of that edge; ignored in IDLE/DONE.
REQ-029 Push while full (and no pop same edge): entry dropped, Lap_Ovf set.
REQ-030 Lap_Rd while non-empty pops; ignored while empty; push+pop same edge when full both succeed, Lap_Count unchanged.
REQ-031 Clear (Reset_S accepted): time, Lap_Count, Lap_Ovf to 0 on that edge.
REQ-032 Control=1 overrides all: no counting, no state change, no push/pop; outputs hold.

Reset
REQ-033 Reset low SHALL asynchronously force IDLE, all time outputs 0, lap buffer empty, Lap_Count 0, Lap_Ovf 0, Running 0, Done 0, direction up.
REQ-034 Reset released mid-operation: next edge evaluated from IDLE; no partial count.

Verification
REQ-035 Up, Start_S 1 edge, run 3,600,000 edges -> 1:00:00.000, Running=1.
REQ-036 HOUR_WRAP=12, preset 11:59:59 up, run 1000 edges -> 0:00:00.000, no Done.
REQ-037 Down, preset 0:00:02, Start_S, 2000 edges -> zero, Done=1, Running=0; further edges hold.
REQ-038 LAP_DEPTH=8, 9 Lap_S in RUN -> Lap_Count=8, Lap_Ovf=1, head = first capture; 8 Lap_Rd -> Lap_Count=0.
REQ-039 Reset_S in RUN ignored; Stop_S then Reset_S -> IDLE, all zero; Control=1 for 100 edges in RUN -> time unchanged.
REQ-040 Reset asserted mid-RUN between edges -> outputs 0 immediately, before next clock edge.
